// File: rtl/dct_tr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dct_tr_pkg
// Description : Shared constants, grant encoding and transpose-address helper
//               for the DCT transpose RAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dct_tr_pkg;

    localparam int BLK_SIZE   = 16;
    localparam int BANK_BIT   = 4;
    localparam int OBUF_DEPTH = 3;

    localparam logic [3:0] CNT_LAST = 4'(BLK_SIZE - 1);

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_e;

    // Row-major index of the cnt-th coefficient in column-major order.
    function automatic logic [3:0] tr_index(input logic [3:0] cnt);
        return {cnt[1:0], cnt[3:2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dct_tr_obuf.sv
`default_nettype none
// ============================================================================
// Module      : dct_tr_obuf
// Description : 3-entry shift FIFO of {last, data}; head entry drives outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module dct_tr_obuf
    import dct_tr_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W:0]   push_data_i,
    input  logic              pop_i,
    output logic [DATA_W:0]   head_o,
    output logic [1:0]        count_o
);

    logic [DATA_W:0] entry_q [OBUF_DEPTH];
    logic [DATA_W:0] entry_d [OBUF_DEPTH];
    logic [1:0]      count_q;
    logic [1:0]      count_d;
    logic            do_pop;
    logic            do_push;
    logic [1:0]      wr_idx;

    always_comb begin
        entry_d = entry_q;
        do_pop  = pop_i && (count_q != 2'd0);
        do_push = push_i && ((count_q < 2'(OBUF_DEPTH)) || do_pop);
        wr_idx  = count_q - 2'(do_pop);
        if (do_pop) begin
            for (int i = 0; i < OBUF_DEPTH - 1; i++) begin
                entry_d[i] = entry_q[i + 1];
            end
        end
        if (do_push) begin
            entry_d[wr_idx] = push_data_i;
        end
        count_d = count_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            count_q <= 2'd0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

    assign head_o  = entry_q[0];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/dct_transpose_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dct_transpose_ctrl
// Description : Ping-pong transpose RAM sequencer and single-port arbiter
//               between the row and column DCT stages.
//               DCT_TRANSPOSE_RR_ARB_EN selects round-robin arbitration;
//               otherwise reads win every conflict.
// Revision    : 1.0 - initial release
// ============================================================================
module dct_transpose_ctrl
    import dct_tr_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    input  logic              out_ready_i,
    output logic              mem_cen_o,
    output logic              mem_oen_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    logic [1:0]        full_q, full_d;
    logic              wb_q, wb_d;
    logic              rb_q, rb_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [3:0]        rcnt_q, rcnt_d;
    logic              rd_inflight_q, rd_inflight_d;
    logic              rd_last_q, rd_last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef DCT_TRANSPOSE_RR_ARB_EN
    logic              prio_rd_q, prio_rd_d;
`endif

    gnt_e              gnt;
    logic              wr_req;
    logic              rd_req;
    logic              wr_win;
    logic [1:0]        obuf_count;
    logic [DATA_W:0]   obuf_head;
    logic              obuf_pop;

    always_comb begin
        full_d        = full_q;
        wb_d          = wb_q;
        rb_d          = rb_q;
        wcnt_d        = wcnt_q;
        rcnt_d        = rcnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;

        wr_req = !full_q[wb_q];
        // Credit check counts the read already on its way into the FIFO.
        rd_req = full_q[rb_q] &&
                 (({1'b0, obuf_count} + {2'b0, rd_inflight_q}) < 3'(OBUF_DEPTH));

`ifdef DCT_TRANSPOSE_RR_ARB_EN
        wr_win    = wr_req && (!rd_req || !prio_rd_q);
        prio_rd_d = prio_rd_q;
        if (wr_req && rd_req) begin
            prio_rd_d = wr_win;
        end
`else
        wr_win = wr_req && !rd_req;
`endif

        if (wr_win && in_valid_i) begin
            gnt = GNT_WR;
        end else if (rd_req && !wr_win) begin
            gnt = GNT_RD;
        end else begin
            gnt = GNT_IDLE;
        end

        rd_inflight_d = (gnt == GNT_RD);
        rd_last_d     = (gnt == GNT_RD) && (rcnt_q == CNT_LAST);

        if (gnt == GNT_WR) begin
            addr_d                 = '0;
            addr_d[BANK_BIT]       = wb_q;
            addr_d[BANK_BIT-1:0]   = wcnt_q;
            wdata_d                = in_data_i;
            wcnt_d                 = wcnt_q + 4'd1;
            if (wcnt_q == CNT_LAST) begin
                full_d[wb_q] = 1'b1;
                wb_d         = !wb_q;
            end
        end else if (gnt == GNT_RD) begin
            addr_d                 = '0;
            addr_d[BANK_BIT]       = rb_q;
            addr_d[BANK_BIT-1:0]   = tr_index(rcnt_q);
            rcnt_d                 = rcnt_q + 4'd1;
            if (rcnt_q == CNT_LAST) begin
                full_d[rb_q] = 1'b0;
                rb_d         = !rb_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q        <= 2'b00;
            wb_q          <= 1'b0;
            rb_q          <= 1'b0;
            wcnt_q        <= 4'd0;
            rcnt_q        <= 4'd0;
            rd_inflight_q <= 1'b0;
            rd_last_q     <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
`ifdef DCT_TRANSPOSE_RR_ARB_EN
            prio_rd_q     <= 1'b0;
`endif
        end else begin
            full_q        <= full_d;
            wb_q          <= wb_d;
            rb_q          <= rb_d;
            wcnt_q        <= wcnt_d;
            rcnt_q        <= rcnt_d;
            rd_inflight_q <= rd_inflight_d;
            rd_last_q     <= rd_last_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
`ifdef DCT_TRANSPOSE_RR_ARB_EN
            prio_rd_q     <= prio_rd_d;
`endif
        end
    end

    assign obuf_pop = out_valid_o && out_ready_i;

    dct_tr_obuf #(
        .DATA_W      (DATA_W)
    ) u_obuf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rd_inflight_q),
        .push_data_i ({rd_last_q, mem_data_i}),
        .pop_i       (obuf_pop),
        .head_o      (obuf_head),
        .count_o     (obuf_count)
    );

    assign in_ready_o  = wr_win;
    assign out_valid_o = (obuf_count != 2'd0);
    assign out_data_o  = obuf_head[DATA_W-1:0];
    assign out_last_o  = obuf_head[DATA_W];

    // Idle cycles replay the held address/data so the RAM pins stay quiet.
    assign mem_cen_o  = (gnt == GNT_IDLE);
    assign mem_wen_o  = (gnt != GNT_WR);
    assign mem_oen_o  = 1'b0;
    assign mem_addr_o = addr_d;
    assign mem_data_o = wdata_d;

endmodule
`default_nettype wire

// File: tb/tb_dct_transpose_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dct_transpose_ctrl
// Description : Directed self-checking bench for dct_transpose_ctrl with a
//               1-cycle-latency RAM model and a transposing scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dct_transpose_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        mem_cen;
    logic        mem_oen;
    logic        mem_wen;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] ram [32];

    int n_chk = 0;
    int n_err = 0;
    int ncyc  = 0;
    int acc_n = 0;
    int rd_n  = 0;
    int out_n = 0;
    int t_acc = -1;
    int t_val = -1;
    logic [1:0]  glog [64];
    logic [15:0] blk  [16];
    logic [16:0] exp_q [$];
    int perm [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

`ifdef DCT_TRANSPOSE_RR_ARB_EN
    localparam int LAT = 19;
`else
    localparam int LAT = 18;
`endif

    always #5 clk = ~clk;

    dct_transpose_ctrl #(
        .DATA_W      (16),
        .ADDR_W      (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_ready_i (out_ready),
        .mem_cen_o   (mem_cen),
        .mem_oen_o   (mem_oen),
        .mem_wen_o   (mem_wen),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_wdata),
        .mem_data_i  (mem_rdata)
    );

    always @(posedge clk) begin
        if (!mem_cen) begin
            if (!mem_wen) ram[mem_addr] <= mem_wdata;
            else          mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, ncyc);
        end
    endtask

    // Protocol checks, input capture and output scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic [3:0] rc;
        if (rst) begin
            acc_n = 0; rd_n = 0; out_n = 0; t_acc = -1; t_val = -1;
            exp_q.delete();
        end else begin
            chk("wr_strobe", {31'b0, ~mem_cen & ~mem_wen}, {31'b0, in_valid & in_ready});
            chk("oen", {31'b0, mem_oen}, 32'd0);
            if (!mem_cen && !mem_wen) begin
                chk("wr_addr", {27'b0, mem_addr}, {27'b0, acc_n[4], acc_n[3:0]});
                chk("wr_data", {16'b0, mem_wdata}, {16'b0, in_data});
            end
            if (!mem_cen && mem_wen) begin
                rc = rd_n[3:0];
                chk("rd_addr", {27'b0, mem_addr}, {27'b0, rd_n[4], rc[1:0], rc[3:2]});
                rd_n++;
            end
            if (in_valid && in_ready) begin
                if (t_acc < 0) t_acc = ncyc;
                blk[acc_n % 16] = in_data;
                acc_n++;
                if (acc_n % 16 == 0) begin
                    for (int j = 0; j < 16; j++) exp_q.push_back({j == 15, blk[perm[j]]});
                end
            end
            if (t_acc >= 0 && ncyc - t_acc < 64)
                glog[ncyc - t_acc] = mem_cen ? 2'd0 : (!mem_wen ? 2'd1 : 2'd2);
            if (out_valid && t_val < 0) t_val = ncyc;
            if (out_valid && out_ready) begin
                out_n++;
                if (exp_q.size() == 0) begin
                    chk("out_extra", {15'b0, out_last, out_data}, 32'h1ffff);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    chk("out_data", {16'b0, out_data}, {16'b0, e[15:0]});
                    chk("out_last", {31'b0, out_last}, {31'b0, e[16]});
                end
            end
        end
        ncyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_data = 16'd0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_reset();
        @(negedge clk);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_last",  {31'b0, out_last},  32'd0);
        chk("rst_out_data",  {16'b0, out_data},  32'd0);
        chk("rst_cen",       {31'b0, mem_cen},   32'd1);
        chk("rst_wen",       {31'b0, mem_wen},   32'd1);
        chk("rst_oen",       {31'b0, mem_oen},   32'd0);
        chk("rst_addr",      {27'b0, mem_addr},  32'd0);
        chk("rst_mdata",     {16'b0, mem_wdata}, 32'd0);
        step();
    endtask

    task automatic send(input int base, input int n);
        logic acc;
        int   w;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(base + i);
            w = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                step();
                w++;
            end while (!acc && w < 200);
            if (!acc) begin
                chk("send_accept", {31'b0, acc}, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 500) begin
            step();
            w++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        int nrd;
        rst = 1'b1; in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b0;

        // Reset state and a single block with first-output latency.
        do_reset();
        check_reset();
        out_ready = 1'b1;
        send(0, 16);
        wait_drain();
        chk("latency", t_val - t_acc, LAT);
        chk("blk1_outs", out_n, 32'd16);

        // Three back-to-back blocks; the grant log shows the conflict policy.
        do_reset();
        step();
        out_ready = 1'b1;
        send(0, 32);
        send(100, 16);
        wait_drain();
        chk("b2b_outs", out_n, 32'd48);
`ifdef DCT_TRANSPOSE_RR_ARB_EN
        chk("arb_c16", {30'b0, glog[16]}, 32'd1);
        chk("arb_c17", {30'b0, glog[17]}, 32'd2);
        chk("arb_c18", {30'b0, glog[18]}, 32'd1);
        chk("arb_c19", {30'b0, glog[19]}, 32'd2);
`else
        nrd = 0;
        for (int c = 16; c < 32; c++) if (glog[c] == 2'd2) nrd++;
        chk("arb_rd_run", nrd, 32'd16);
        chk("arb_wr_after", {30'b0, glog[32]}, 32'd1);
`endif

        // Backpressure: three reads buffered, both banks fill, then release.
        do_reset();
        step();
        out_ready = 1'b0;
        send(200, 32);
        repeat (4) step();
        @(negedge clk);
        chk("bp_in_ready",  {31'b0, in_ready},  32'd0);
        chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_reads",     rd_n,  32'd3);
        chk("bp_accepts",   acc_n, 32'd32);
        step();
        out_ready = 1'b1;
        wait_drain();
        chk("bp_outs", out_n, 32'd32);

        // Reset in the middle of draining, then a clean block.
        do_reset();
        step();
        out_ready = 1'b1;
        begin
            int   k;
            logic acc;
            k = 0;
            for (int c = 0; c < 20; c++) begin
                in_valid = 1'b1;
                in_data  = 16'(k);
                @(negedge clk);
                acc = in_ready;
                step();
                if (acc) k++;
            end
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset();
        send(50, 16);
        wait_drain();
        chk("mid_rst_outs", out_n, 32'd16);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", ncyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
